fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined processor; feeds the IF/ID register consumed by decode.
//  Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel.
//  Buffers returned instructions so a decode stall never loses a fetch.
//  Accepts branch/jump redirects from EX: kills in-flight fetches and restarts at the target.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h00000000  PC fetched first after reset
//  DEPTH     2             max fetches in flight + buffered (credit limit), >=1
// PORTS
//  clock               in   1     single clock, all state on rising edge
//  reset               in   1     synchronous, active-high
//  io_imem_req_valid   out  1     fetch request valid
//  io_imem_req_ready   in   1     imem accepts request this cycle
//  io_imem_req_addr    out  XLEN  fetch address (= PC)
//  io_imem_resp_valid  in   1     instruction returned (in request order, >=1 cycle after accept)
//  io_imem_resp_inst   in   32    returned instruction word
//  io_stall            in   1     decode hazard: hold IF/ID contents
//  io_redirect_valid   in   1     EX redirect (taken branch/jump)
//  io_redirect_pc      in   XLEN  redirect target
//  io_id_valid         out  1     IF/ID holds a live instruction
//  io_id_pc            out  XLEN  PC of IF/ID instruction
//  io_id_inst          out  32    IF/ID instruction (NOP 32'h00000013 when invalid)
// BEHAVIOUR
//  Reset: pc=RESET_PC, inflight=0, drop=0, fifo empty, id_valid=0, id_pc=0, id_inst=NOP, req_valid=0 during reset.
//  Issue: req_valid = !redirect && (inflight + fifo_count < DEPTH); addr=pc. On accept: pc+=4 (mod 2^XLEN),
//   push pc into pc-tag queue, inflight++. Addr/valid held stable while ready low.
//  Response: if drop>0 -> discard, drop--, inflight--; else pop pc tag, inflight--, deliver {tag,inst}.
//   Simultaneous accept+response: inflight unchanged.
//  IF/ID update when !stall: load fifo head if non-empty, else bypass live response, else id_valid=0, id_inst=NOP.
//   Live response not consumed by bypass is pushed to fifo. Fifo never overflows (credit rule).
//  Latency: request accepted cycle N, response cycle N+1 -> io_id_valid in N+2. Steady state 1 instr/cycle, no gaps.
//  Stall: IF/ID frozen; fetching continues until credit limit; no duplicated or skipped PCs on release.
//  Redirect (priority over stall): pc<=redirect_pc & ~3 (bits[1:0] forced 0); fifo and pc-tag queue cleared;
//   id_valid<=0, id_inst<=NOP; drop<=inflight minus any response consumed same cycle; no request that cycle.
//   Next-cycle request uses target. Redirect during a pending drop adds to drop (saturating at DEPTH).
//  Reset mid-operation: all state returns to reset values next cycle; imem is reset by the same signal,
//   so no pre-reset responses arrive.
//  Widths: inflight, drop, fifo_count are $clog2(DEPTH+1) bits; PC wrap at 2^XLEN is silent.
// STRUCTURE
//  Shared package: XLEN, NOP_INST=32'h00000013, RESET_PC default, IF/ID bundle typedef {valid,pc,inst}.
//  Sub-module fetch_fifo: DEPTH-entry sync FIFO of {pc,inst}, push/pop/flush, count output; reused
//   for the pc-tag queue (inst field unused).
//  Top: PC reg, credit/drop counters, IF/ID register, bypass mux.
// TESTING (imem model: always ready, 1-cycle latency, inst = addr ^ 32'hA5A5_0000 unless stated)
//  1 Reset 2 cycles, release -> id_pc 0,4,8,12 on consecutive cycles starting 2 cycles after release; id_inst matches model.
//  2 Stall held 3 cycles at id_pc=8 -> id_pc stays 8, <=DEPTH accepts during stall; after release 12,16,... with no gap or repeat.
//  3 Redirect to 32'h100 with 2 fetches in flight -> both responses dropped, id_valid=0 for 2 cycles, next id_pc=32'h100.
//  4 req_ready low 4 cycles -> req_addr stable, id_valid=0 bubbles after fifo drains, resumes at held addr in order.
//  5 Redirect 32'h102 with stall asserted same cycle -> redirect wins; next fetch addr 32'h100, id_inst=NOP meanwhile.
//  6 Reset asserted mid-stream at id_pc=32'h20 -> next cycle id_valid=0, id_inst=NOP, first request after release = RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN      : default data/address width
//   NOP_INST  : instruction presented on IF/ID when it holds nothing live (addi x0,x0,0)
//   RESET_PC  : default first fetch address after reset
//   ifid_t    : IF/ID bundle {valid, pc, inst} as seen by decode
package fetch_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC = '0;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } ifid_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage: as the response buffer ({pc,inst})
// and as the pc-tag queue of outstanding requests (pc only).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : empties the FIFO (takes priority over push/pop)
//   push, wdata  : write one entry (caller guarantees not full)
//   pop          : drop the head entry (caller guarantees not empty)
//   rdata        : head entry, valid whenever count != 0
//   count        : number of stored entries, 0..DEPTH
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    count_q;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem_q[wr_q] <= wdata;
   end

   assign rdata = mem_q[rd_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to instruction memory,
// buffers returned instructions so a decode stall never loses one, and handles EX redirects
// by killing in-flight fetches and restarting at the target.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   io_imem_req_*       : fetch request channel (valid/ready, addr = PC)
//   io_imem_resp_*      : in-order instruction returns, >=1 cycle after accept
//   io_stall            : decode hazard, hold IF/ID
//   io_redirect_*       : taken branch/jump target from EX (wins over stall)
//   io_id_*             : IF/ID register presented to decode
module fetch_stage #(
   parameter int unsigned      XLEN     = fetch_stage_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = fetch_stage_pkg::RESET_PC,
   parameter int unsigned      DEPTH    = 2
) (
   input  logic            clock,
   input  logic            reset,
   output logic            io_imem_req_valid,
   input  logic            io_imem_req_ready,
   output logic [XLEN-1:0] io_imem_req_addr,
   input  logic            io_imem_resp_valid,
   input  logic [31:0]     io_imem_resp_inst,
   input  logic            io_stall,
   input  logic            io_redirect_valid,
   input  logic [XLEN-1:0] io_redirect_pc,
   output logic            io_id_valid,
   output logic [XLEN-1:0] io_id_pc,
   output logic [31:0]     io_id_inst
);

   import fetch_stage_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [31:0]     id_inst_q, id_inst_d;

   logic [CW-1:0]   inflight, tag_count, buf_count;
   logic [XLEN-1:0] tag_pc, buf_pc;
   logic [31:0]     buf_inst;
   logic            credit_ok, accept, resp_drop, resp_live;
   logic            buf_nonempty, bypass, buf_push, buf_pop;

   // Every outstanding request either still owns a pc tag or is counted as to-be-dropped,
   // so the in-flight count is exactly the sum of the two.
   assign inflight     = tag_count + drop_q;
   assign buf_nonempty = (buf_count != '0);
   assign credit_ok    = ({1'b0, inflight} + {1'b0, buf_count}) < SW'(DEPTH);

   assign io_imem_req_valid = !reset && !io_redirect_valid && credit_ok;
   assign io_imem_req_addr  = pc_q;
   assign accept            = io_imem_req_valid && io_imem_req_ready;

   assign resp_drop = io_imem_resp_valid && (drop_q != '0);
   assign resp_live = io_imem_resp_valid && (drop_q == '0);

   // Buffered instructions are older than the live response, so they go first.
   assign buf_pop  = !io_redirect_valid && !io_stall && buf_nonempty;
   assign bypass   = !io_redirect_valid && !io_stall && !buf_nonempty && resp_live;
   assign buf_push = !io_redirect_valid && resp_live && !bypass;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_tag_q (
      .clock (clock),
      .reset (reset),
      .flush (io_redirect_valid),
      .push  (accept),
      .wdata (pc_q),
      .pop   (resp_live),
      .rdata (tag_pc),
      .count (tag_count)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN + 32)
   ) u_buf_q (
      .clock (clock),
      .reset (reset),
      .flush (io_redirect_valid),
      .push  (buf_push),
      .wdata ({tag_pc, io_imem_resp_inst}),
      .pop   (buf_pop),
      .rdata ({buf_pc, buf_inst}),
      .count (buf_count)
   );

   always_comb begin
      pc_d       = pc_q;
      drop_d     = drop_q;
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;

      if (io_redirect_valid) begin
         pc_d       = io_redirect_pc & ~XLEN'(3);
         // Tags are flushed, so everything still outstanding after this cycle must be dropped.
         drop_d     = inflight - CW'(io_imem_resp_valid);
         id_valid_d = 1'b0;
         id_inst_d  = NOP_INST;
      end else begin
         if (accept)    pc_d   = pc_q + XLEN'(4);
         if (resp_drop) drop_d = drop_q - CW'(1);
         if (!io_stall) begin
            if (buf_nonempty) begin
               id_valid_d = 1'b1;
               id_pc_d    = buf_pc;
               id_inst_d  = buf_inst;
            end else if (resp_live) begin
               id_valid_d = 1'b1;
               id_pc_d    = tag_pc;
               id_inst_d  = io_imem_resp_inst;
            end else begin
               id_valid_d = 1'b0;
               id_inst_d  = NOP_INST;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         drop_q     <= '0;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= NOP_INST;
      end else begin
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
      end
   end

   assign io_id_valid = id_valid_q;
   assign io_id_pc    = id_pc_q;
   assign io_id_inst  = id_inst_q;

endmodule
